// File: rtl/time_of_day_pkg.sv
// -----------------------------------------------------------------------------
// time_of_day_pkg
// Shared definitions for the time-of-day counter: BCD field widths, the
// load-FSM state encoding, reset time constants and BCD helper functions.
// No ports (package).
// -----------------------------------------------------------------------------
package time_of_day_pkg;

   localparam int NIBBLE_W = 4;   // one BCD digit
   localparam int FIELD_W  = 8;   // one two-digit field (hh, mm or ss)
   localparam int TIME_W   = 24;  // {hh, mm, ss}

   // Load handshake FSM. RUN is the only state that counts and accepts loads.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2
   } tod_state_e;

   localparam logic [TIME_W-1:0] RST_TIME_24H = 24'h000000;  // 00:00:00
   localparam logic [TIME_W-1:0] RST_TIME_12H = 24'h120000;  // 12:00:00 AM

   // A load value is legal when every digit is decimal and the fields are a
   // real 24-hour time. Loads are always given in 24-hour form.
   function automatic logic time_legal(input logic [TIME_W-1:0] t);
      return (t[3:0]   <= 4'd9) && (t[7:4]   <= 4'd5) &&
             (t[11:8]  <= 4'd9) && (t[15:12] <= 4'd5) &&
             (t[19:16] <= 4'd9) && (t[23:16] <= 8'h23);
   endfunction

   // 24-hour BCD hour (00..23) to 12-hour BCD hour (12, 01..11).
   // Only called on values already accepted by time_legal.
   function automatic logic [FIELD_W-1:0] hh_24_to_12(input logic [FIELD_W-1:0] hh);
      logic [4:0]          h;
      logic [4:0]          h12;
      logic [NIBBLE_W-1:0] tens;
      logic [NIBBLE_W-1:0] ones;
      h = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
      if (h == 5'd0)
         h12 = 5'd12;
      else if (h > 5'd12)
         h12 = h - 5'd12;
      else
         h12 = h;
      if (h12 >= 5'd10) begin
         tens = 4'd1;
         ones = 4'(h12 - 5'd10);
      end else begin
         tens = 4'd0;
         ones = 4'(h12);
      end
      return {tens, ones};
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter covering MODULUS consecutive values starting at
// MIN_VAL (decimal). Increments by one per inc, wrapping from the top value
// back to MIN_VAL with a same-cycle carry. A load overrides inc.
//
// Parameters:
//   MODULUS  number of distinct values (60 for ss/mm, 24 or 12 for hh)
//   MIN_VAL  lowest value, decimal (0, or 1 for a 12-hour clock)
//   RST_VAL  BCD value taken on reset
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   inc       advance by one this cycle
//   load      replace the value with load_val this cycle
//   load_val  BCD value to load
//   val       current BCD value {tens, ones}
//   carry     combinational: inc while at the top value (wrap this cycle)
// -----------------------------------------------------------------------------
module bcd_mod_counter
   import time_of_day_pkg::*;
#(
   parameter int                 MODULUS = 60,
   parameter int                 MIN_VAL = 0,
   parameter logic [FIELD_W-1:0] RST_VAL = 8'h00
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               load,
   input  logic [FIELD_W-1:0] load_val,
   output logic [FIELD_W-1:0] val,
   output logic               carry
);

   localparam int                 MAX_VAL = MIN_VAL + MODULUS - 1;
   localparam logic [FIELD_W-1:0] MIN_BCD = {4'(MIN_VAL / 10), 4'(MIN_VAL % 10)};
   localparam logic [FIELD_W-1:0] MAX_BCD = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};

   logic [NIBBLE_W-1:0] tens;
   logic [NIBBLE_W-1:0] ones;

   assign tens  = val[7:4];
   assign ones  = val[3:0];
   assign carry = inc & (val == MAX_BCD);

   always_ff @(posedge clk) begin
      if (rst)
         val <= RST_VAL;
      else if (load)
         val <= load_val;
      else if (inc) begin
         if (val == MAX_BCD)
            val <= MIN_BCD;
         else if (ones == 4'd9)
            val <= {tens + 4'd1, 4'd0};   // x9 -> (x+1)0
         else
            val <= {tens, ones + 4'd1};
      end
   end

endmodule

// File: rtl/time_of_day_counter.sv
// -----------------------------------------------------------------------------
// time_of_day_counter
// BCD time-of-day clock advanced by a square wave. Every EDGES_PER_SEC rising
// edges of sw advance the seconds by one; ss/mm/hh cascade through three
// bcd_mod_counter instances. A load handshake sets the time after a
// legality check.
//
// Build option: define TIME_OF_DAY_12H_EN for a 12-hour display (hh runs
// 12,01..11 with a pm flag). Loads are always supplied in 24-hour form and
// converted; pm of a loaded value is hh >= 12. Default build is 24-hour.
//
// Parameter:
//   EDGES_PER_SEC  sw rising edges per second, 1..2^16
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   sw          square wave, synchronous to clk
//   load_valid  time-set request
//   load_time   BCD {hh, mm, ss}, 24-hour form
//   load_ready  high when a load can be accepted (RUN state, not in reset)
//   load_err    one-cycle pulse when an accepted load was illegal
//   time_bcd    current BCD {hh, mm, ss}
//   sec_pulse   one-cycle pulse on every seconds increment
//   day_wrap    one-cycle pulse when the time wraps to the first time of day
//   pm          PM flag
//   dbg_state   current load-FSM state (tod_state_e encoding)
//
// Handshake: a load transfers in any cycle where load_valid and load_ready
// are both high. load_time is captured one cycle later (LOAD state), so the
// requester holds it for that cycle. The result (new time or load_err) is
// visible two cycles after that, when load_ready returns high.
// -----------------------------------------------------------------------------
module time_of_day_counter
   import time_of_day_pkg::*;
#(
   parameter logic [31:0] EDGES_PER_SEC = 32'd1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw,
   input  logic              load_valid,
   input  logic [TIME_W-1:0] load_time,
   output logic              load_ready,
   output logic              load_err,
   output logic [TIME_W-1:0] time_bcd,
   output logic              sec_pulse,
   output logic              day_wrap,
   output logic              pm,
   output logic [1:0]        dbg_state
);

   localparam int            PW        = (EDGES_PER_SEC > 32'd1) ? $clog2(EDGES_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(EDGES_PER_SEC - 32'd1);

`ifdef TIME_OF_DAY_12H_EN
   localparam logic [TIME_W-1:0] RST_TIME = RST_TIME_12H;
   localparam int                HH_MOD   = 12;
   localparam int                HH_MIN   = 1;
`else
   localparam logic [TIME_W-1:0] RST_TIME = RST_TIME_24H;
   localparam int                HH_MOD   = 24;
   localparam int                HH_MIN   = 0;
`endif

   tod_state_e          state;
   logic                sw_d;
   logic [PW-1:0]       presc;
   logic [TIME_W-1:0]   load_q;

   logic                sw_rise;
   logic                load_acc;
   logic                cnt_edge;
   logic                tick;
   logic                chk_ok;
   logic                chk_bad;
   logic                wrap_now;

   logic [FIELD_W-1:0]  ss;
   logic [FIELD_W-1:0]  mm;
   logic [FIELD_W-1:0]  hh;
   logic [FIELD_W-1:0]  hh_load;
   logic                ss_carry;
   logic                mm_carry;
   logic                hh_carry;

   assign load_ready = (state == ST_RUN) & ~rst;
   assign sw_rise    = sw & ~sw_d;
   assign load_acc   = load_valid & load_ready;
   // Edges only count in RUN; an edge coinciding with an accepted load is lost.
   assign cnt_edge   = sw_rise & (state == ST_RUN) & ~load_acc;
   assign tick       = cnt_edge & (presc == PRESC_MAX);
   assign chk_ok     = (state == ST_CHECK) &  time_legal(load_q);
   assign chk_bad    = (state == ST_CHECK) & ~time_legal(load_q);

   bcd_mod_counter #(.MODULUS(60), .MIN_VAL(0), .RST_VAL(RST_TIME[7:0])) u_ss (
      .clk      (clk),
      .rst      (rst),
      .inc      (tick),
      .load     (chk_ok),
      .load_val (load_q[7:0]),
      .val      (ss),
      .carry    (ss_carry)
   );

   bcd_mod_counter #(.MODULUS(60), .MIN_VAL(0), .RST_VAL(RST_TIME[15:8])) u_mm (
      .clk      (clk),
      .rst      (rst),
      .inc      (ss_carry),
      .load     (chk_ok),
      .load_val (load_q[15:8]),
      .val      (mm),
      .carry    (mm_carry)
   );

   bcd_mod_counter #(.MODULUS(HH_MOD), .MIN_VAL(HH_MIN), .RST_VAL(RST_TIME[23:16])) u_hh (
      .clk      (clk),
      .rst      (rst),
      .inc      (mm_carry),
      .load     (chk_ok),
      .load_val (hh_load),
      .val      (hh),
      .carry    (hh_carry)
   );

`ifdef TIME_OF_DAY_12H_EN
   logic pm_q;
   logic hh_to12;
   logic unused_hh_carry;

   // The 12 -> 01 hour wrap is not the day boundary; 11 -> 12 is, when in PM.
   assign hh_to12         = mm_carry & (hh == 8'h11);
   assign unused_hh_carry = hh_carry;
   assign hh_load         = hh_24_to_12(load_q[23:16]);
   assign wrap_now        = hh_to12 & pm_q;
   assign pm              = pm_q;

   always_ff @(posedge clk) begin
      if (rst)
         pm_q <= 1'b0;
      else if (chk_ok)
         pm_q <= (load_q[23:16] >= 8'h12);
      else if (hh_to12)
         pm_q <= ~pm_q;
   end
`else
   assign hh_load  = load_q[23:16];
   assign wrap_now = hh_carry;
   assign pm       = (hh >= 8'h12);
`endif

   assign time_bcd  = {hh, mm, ss};
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         sw_d      <= 1'b1;   // sw already high at reset release is not an edge
         presc     <= '0;
         load_q    <= '0;
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         sw_d      <= sw;
         sec_pulse <= tick;
         day_wrap  <= wrap_now;
         load_err  <= chk_bad;

         if (chk_ok)
            presc <= '0;
         else if (cnt_edge)
            presc <= tick ? '0 : presc + PW'(1);

         case (state)
            ST_RUN: begin
               if (load_acc)
                  state <= ST_LOAD;
            end
            ST_LOAD: begin
               load_q <= load_time;
               state  <= ST_CHECK;
            end
            ST_CHECK: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time_of_day_counter.sv
// -----------------------------------------------------------------------------
// tb_time_of_day_counter
// Self-checking bench for time_of_day_counter (EDGES_PER_SEC = 4). The
// reference model keeps the time as seconds-of-day plus an edge count and a
// busy countdown for the load handshake; displays are derived arithmetically.
// Works in either build (TIME_OF_DAY_12H_EN defined or not).
// -----------------------------------------------------------------------------
module tb_time_of_day_counter;
   import time_of_day_pkg::ST_RUN;

   localparam int EPS = 4;
   localparam int DAY = 86400;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        sw;
   logic        load_valid;
   logic [23:0] load_time;
   logic        load_ready;
   logic        load_err;
   logic [23:0] time_bcd;
   logic        sec_pulse;
   logic        day_wrap;
   logic        pm;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   time_of_day_counter #(.EDGES_PER_SEC(32'(EPS))) dut (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw),
      .load_valid (load_valid),
      .load_time  (load_time),
      .load_ready (load_ready),
      .load_err   (load_err),
      .time_bcd   (time_bcd),
      .sec_pulse  (sec_pulse),
      .day_wrap   (day_wrap),
      .pm         (pm),
      .dbg_state  (dbg_state)
   );

   // ---------------- reference model ----------------
   int          m_sod;
   int          m_presc;
   int          m_busy;      // 2: next cycle latches, 1: next cycle checks, 0: idle
   logic        m_prev_sw;
   logic [23:0] m_lat;
   logic [28:0] exp_q[$];    // {ready, err, pulse, wrap, pm, time}

   int n_checks = 0;
   int n_pass   = 0;

   function automatic int digit(input logic [23:0] t, input int i);
      return int'(t[4*i +: 4]);
   endfunction

   function automatic bit bcd_legal(input logic [23:0] t);
      for (int i = 0; i < 6; i++)
         if (digit(t, i) > 9) return 1'b0;
      return (digit(t, 1) * 10 + digit(t, 0) < 60) &&
             (digit(t, 3) * 10 + digit(t, 2) < 60) &&
             (digit(t, 5) * 10 + digit(t, 4) < 24);
   endfunction

   function automatic int bcd_to_sod(input logic [23:0] t);
      return (digit(t, 5) * 10 + digit(t, 4)) * 3600 +
             (digit(t, 3) * 10 + digit(t, 2)) * 60 +
             (digit(t, 1) * 10 + digit(t, 0));
   endfunction

   function automatic logic [7:0] two_digits(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [23:0] sod_to_disp(input int sod);
      int h;
      h = sod / 3600;
`ifdef TIME_OF_DAY_12H_EN
      h = (h % 12 == 0) ? 12 : h % 12;
`endif
      return {two_digits(h), two_digits((sod / 60) % 60), two_digits(sod % 60)};
   endfunction

   function automatic logic [23:0] pick_time();
      case ($urandom_range(0, 3))
         0:       return {8'h23, 8'h59, ($urandom_range(0, 1) != 0) ? 8'h59 : 8'h58};
         1:       return {two_digits(int'($urandom_range(0, 23))),
                          two_digits(int'($urandom_range(0, 59))),
                          two_digits(int'($urandom_range(0, 59)))};
         2:       return 24'($urandom);
         default: return 24'h115959;
      endcase
   endfunction

   // Advance the model over the cycle whose inputs are currently driven.
   task automatic model_step();
      logic e_err;
      logic e_pulse;
      logic e_wrap;
      e_err = 1'b0; e_pulse = 1'b0; e_wrap = 1'b0;
      if (rst) begin
         m_sod = 0; m_presc = 0; m_busy = 0; m_prev_sw = 1'b1;
      end else begin
         if (m_busy == 2) begin
            m_lat  = load_time;
            m_busy = 1;
         end else if (m_busy == 1) begin
            m_busy = 0;
            if (bcd_legal(m_lat)) begin
               m_sod   = bcd_to_sod(m_lat);
               m_presc = 0;
            end else
               e_err = 1'b1;
         end else if (load_valid) begin
            m_busy = 2;
         end else if (sw && !m_prev_sw) begin
            m_presc++;
            if (m_presc == EPS) begin
               m_presc = 0;
               e_pulse = 1'b1;
               m_sod++;
               if (m_sod == DAY) begin
                  m_sod  = 0;
                  e_wrap = 1'b1;
               end
            end
         end
         m_prev_sw = sw;
      end
      exp_q.push_back({(!rst && m_busy == 0), e_err, e_pulse, e_wrap,
                       (m_sod >= DAY / 2), sod_to_disp(m_sod)});
   endtask

   // ---------------- scoreboard / driver tasks ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   task automatic cyc();
      logic [28:0] e;
      model_step();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("scoreboard", {3'b0, load_ready, load_err, sec_pulse, day_wrap, pm, time_bcd},
            {3'b0, e});
   endtask

   task automatic sw_edge();
      sw = 1'b0; cyc();
      sw = 1'b1; cyc();
   endtask

   task automatic tick();
      repeat (EPS) sw_edge();
   endtask

   // Accept, LOAD, CHECK; returns with the result visible.
   task automatic do_load(input logic [23:0] t);
      load_time  = t;
      load_valid = 1'b1;
      cyc();
      check("ready_low_in_load", 32'(load_ready), 32'd0);
      load_valid = 1'b0;
      cyc();
      check("ready_low_in_check", 32'(load_ready), 32'd0);
      cyc();
      check("ready_back_high", 32'(load_ready), 32'd1);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [23:0] t;
      logic        err;
      logic [23:0] exp24;   // expected time afterwards, 24-hour form
   } load_vec_t;

   load_vec_t vecs[12];

   initial begin
      int pulses;

      vecs[0]  = '{24'h235959, 1'b0, 24'h235959};
      vecs[1]  = '{24'h126000, 1'b1, 24'h235959};
      vecs[2]  = '{24'h123456, 1'b0, 24'h123456};
      vecs[3]  = '{24'h240000, 1'b1, 24'h123456};
      vecs[4]  = '{24'h1A0000, 1'b1, 24'h123456};
      vecs[5]  = '{24'h00005A, 1'b1, 24'h123456};
      vecs[6]  = '{24'h000060, 1'b1, 24'h123456};
      vecs[7]  = '{24'h000000, 1'b0, 24'h000000};
      vecs[8]  = '{24'h195905, 1'b0, 24'h195905};
      vecs[9]  = '{24'h0B0000, 1'b1, 24'h195905};
      vecs[10] = '{24'h096000, 1'b1, 24'h195905};
      vecs[11] = '{24'h120000, 1'b0, 24'h120000};

      // Reset released with sw already high.
      rst = 1'b1; sw = 1'b1; load_valid = 1'b0; load_time = '0;
      cyc(); cyc();
      check("rst_time", 32'(time_bcd), 32'(sod_to_disp(0)));
      check("rst_ready", 32'(load_ready), 32'd0);
      check("rst_pm", 32'(pm), 32'd0);
      check("rst_flags", 32'({sec_pulse, day_wrap, load_err}), 32'd0);
      rst = 1'b0;
      repeat (3) cyc();
      check("run_state", 32'(dbg_state), 32'(ST_RUN));
      check("no_edge_sw_high", 32'(time_bcd), 32'(sod_to_disp(0)));

      // Eight edges at four per second: pulses right after edges 4 and 8.
      pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         sw_edge();
         pulses += int'(sec_pulse);
         check("pulse_at_edge", 32'(sec_pulse), 32'(k % EPS == 0));
      end
      check("pulse_count", 32'(pulses), 32'd2);
      check("time_after_8", 32'(time_bcd), 32'(sod_to_disp(2)));

      // Table of loads, legal and illegal.
      for (int i = 0; i < 12; i++) begin
         do_load(vecs[i].t);
         check("load_err", 32'(load_err), 32'(vecs[i].err));
         check("time_after_load", 32'(time_bcd), 32'(sod_to_disp(bcd_to_sod(vecs[i].exp24))));
         cyc();
         check("load_err_clear", 32'(load_err), 32'd0);
      end

      // Day wrap.
      do_load(24'h235959);
      tick();
      check("wrap_time", 32'(time_bcd), 32'(sod_to_disp(0)));
      check("wrap_pulse", 32'({day_wrap, sec_pulse}), 32'b11);
      cyc();
      check("wrap_pulse_end", 32'({day_wrap, sec_pulse}), 32'b00);

      // Load accepted on the final prescaler edge: edge dropped, prescaler cleared.
      do_load(24'h100000);
      repeat (EPS - 1) sw_edge();
      sw = 1'b0; cyc();
      sw = 1'b1; load_time = 24'h081530; load_valid = 1'b1; cyc();
      check("edge_load_no_pulse", 32'(sec_pulse), 32'd0);
      load_valid = 1'b0;
      cyc(); cyc();
      check("edge_load_time", 32'(time_bcd), 32'(sod_to_disp(bcd_to_sod(24'h081530))));
      repeat (EPS - 1) sw_edge();
      check("presc_cleared", 32'(time_bcd), 32'(sod_to_disp(bcd_to_sod(24'h081530))));
      sw_edge();
      check("first_tick_after_load", 32'(time_bcd), 32'(sod_to_disp(bcd_to_sod(24'h081531))));

      // 11:59:59 -> 12:00:00 raises pm.
      do_load(24'h115959);
      check("pm_before_noon", 32'(pm), 32'd0);
      tick();
      check("noon_time", 32'(time_bcd), 32'(sod_to_disp(DAY / 2)));
      check("noon_pm", 32'(pm), 32'd1);

      // Reset during LOAD, then during CHECK: no load_err, no update.
      load_time = 24'h050505; load_valid = 1'b1; cyc();
      load_valid = 1'b0; rst = 1'b1; cyc();
      rst = 1'b0; cyc();
      check("rst_mid_load_err", 32'(load_err), 32'd0);
      check("rst_mid_load_time", 32'(time_bcd), 32'(sod_to_disp(0)));
      load_time = 24'h250505; load_valid = 1'b1; cyc();
      load_valid = 1'b0; cyc();
      rst = 1'b1; cyc();
      rst = 1'b0; cyc();
      check("rst_mid_check_err", 32'(load_err), 32'd0);
      check("rst_mid_check_time", 32'(time_bcd), 32'(sod_to_disp(0)));

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         int r;
         r          = int'($urandom_range(0, 199));
         rst        = (r == 0);
         load_valid = (r >= 190);
         if ($urandom_range(0, 1) != 0) sw = ~sw;
         if (load_valid || r == 1) load_time = pick_time();
         cyc();
      end

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
